// File: rtl/program_sequencer_if.sv
// Front-panel bus between program_sequencer (slave) and whatever commands it (master).
// STEP_REQ/SS_MODE exist only when SEQ_SINGLE_STEP_EN is defined.
interface program_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          LOAD_EN;
    logic          WR_STB;
    logic [9:0]    WR_DATA;
    logic          RUN;
    logic          DONE;
    logic          EXT;
`ifdef SEQ_SINGLE_STEP_EN
    logic          STEP_REQ;
    logic          SS_MODE;
`endif
    logic [9:0]    WORD;
    logic          STEP;
    logic [AW-1:0] PC;
    logic [AW:0]   PROG_LEN;
    logic          BUSY;
    logic          HALTED;
    logic          FAULT;
    logic [2:0]    DBG_STATE;

    // Handshake: none beyond levels/strobes. WR_STB is a one-cycle strobe qualified
    // by LOAD state; every other input is a level sampled on the rising clock edge.
    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        output STEP_REQ, SS_MODE,
`endif
        output LOAD_EN, WR_STB, WR_DATA, RUN, DONE, EXT,
        input  WORD, STEP, PC, PROG_LEN, BUSY, HALTED, FAULT, DBG_STATE
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        input  STEP_REQ, SS_MODE,
`endif
        input  LOAD_EN, WR_STB, WR_DATA, RUN, DONE, EXT,
        output WORD, STEP, PC, PROG_LEN, BUSY, HALTED, FAULT, DBG_STATE
    );
endinterface

// File: rtl/program_sequencer.sv
// Stores a program of 10-bit words and steps a processor through it via WORD/STEP.
// Optional SEQ_SINGLE_STEP_EN: each step waits for STEP_REQ when SS_MODE=1.
module program_sequencer #(
    parameter int DEPTH       = 16,
    parameter int HALF_PERIOD = 4,
    parameter int MAX_STEPS   = 8
) (
    input  logic CLK50M,
    input  logic RST,
    program_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(HALF_PERIOD);
    localparam int CW = $clog2(MAX_STEPS + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] STEP_LIMIT = CW'(MAX_STEPS);
    localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_STEP_HI = 3'd2,
        S_STEP_LO = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [9:0]    r_mem [DEPTH];
    logic [9:0]    r_word, w_word_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [AW:0]   r_prog_len, w_prog_len_nxt;
    logic          r_halted, w_halted_nxt;
    logic          r_fault, w_fault_nxt;
    logic          r_imm, w_imm_nxt;
    logic [CW-1:0] r_step_cnt, w_step_cnt_nxt;
    logic [PW-1:0] r_phase, w_phase_nxt;
    logic          r_ss_wait, w_ss_wait_nxt;
    logic          w_mem_we;
    logic          w_ss_arm;
    logic          w_ss_req;

    logic [AW:0]   w_pc_inc1;
    logic [AW:0]   w_pc_done;
    logic [CW-1:0] w_step_cnt_inc;

`ifdef SEQ_SINGLE_STEP_EN
    assign w_ss_arm = bus.SS_MODE;
    assign w_ss_req = bus.STEP_REQ;
`else
    assign w_ss_arm = 1'b0;
    assign w_ss_req = 1'b0;
`endif

    // PC is widened by one bit so PC+1(+imm) can reach PROG_LEN==DEPTH without wrapping.
    assign w_pc_inc1      = {1'b0, r_pc} + (AW+1)'(1);
    assign w_pc_done      = w_pc_inc1 + {{AW{1'b0}}, r_imm};
    assign w_step_cnt_inc = r_step_cnt + CW'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_word_nxt     = r_word;
        w_pc_nxt       = r_pc;
        w_prog_len_nxt = r_prog_len;
        w_halted_nxt   = r_halted;
        w_fault_nxt    = r_fault;
        w_imm_nxt      = r_imm;
        w_step_cnt_nxt = r_step_cnt;
        w_phase_nxt    = r_phase;
        w_ss_wait_nxt  = r_ss_wait;
        w_mem_we       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.LOAD_EN) begin
                    w_state_nxt    = S_LOAD;
                    w_prog_len_nxt = '0;
                end else if (bus.RUN) begin
                    if (r_prog_len == '0) begin
                        w_state_nxt = S_HALT;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_STEP_HI;
                        w_pc_nxt       = '0;
                        w_word_nxt     = r_mem[0];
                        w_imm_nxt      = 1'b0;
                        w_step_cnt_nxt = '0;
                        w_phase_nxt    = '0;
                        w_ss_wait_nxt  = w_ss_arm;
                    end
                end
            end

            S_LOAD: begin
                if (bus.WR_STB && (r_prog_len != DEPTH_W)) begin
                    w_mem_we       = 1'b1;
                    w_prog_len_nxt = r_prog_len + (AW+1)'(1);
                end
                if (!bus.LOAD_EN) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_STEP_HI: begin
                if (r_ss_wait) begin
                    if (w_ss_req) begin
                        w_ss_wait_nxt = 1'b0;
                    end
                end else if (r_phase == PHASE_LAST) begin
                    w_phase_nxt = '0;
                    w_state_nxt = S_STEP_LO;
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end

            S_STEP_LO: begin
                if (r_phase != PHASE_LAST) begin
                    w_phase_nxt = r_phase + PW'(1);
                end else begin
                    // End of step: RUN, then DONE, then EXT, then watchdog.
                    w_phase_nxt    = '0;
                    w_step_cnt_nxt = w_step_cnt_inc;
                    if (!bus.RUN) begin
                        w_state_nxt    = S_IDLE;
                        w_pc_nxt       = '0;
                        w_imm_nxt      = 1'b0;
                        w_word_nxt     = '0;
                        w_step_cnt_nxt = '0;
                    end else if (bus.DONE) begin
                        w_pc_nxt       = w_pc_done[AW-1:0];
                        w_imm_nxt      = 1'b0;
                        w_step_cnt_nxt = '0;
                        if (w_pc_done >= r_prog_len) begin
                            w_state_nxt  = S_HALT;
                            w_halted_nxt = 1'b1;
                        end else begin
                            w_word_nxt    = r_mem[w_pc_done[AW-1:0]];
                            w_state_nxt   = S_STEP_HI;
                            w_ss_wait_nxt = w_ss_arm;
                        end
                    end else if (bus.EXT) begin
                        w_imm_nxt = 1'b1;
                        if (w_pc_inc1 >= r_prog_len) begin
                            w_state_nxt = S_HALT;
                            w_fault_nxt = 1'b1;
                        end else begin
                            w_word_nxt    = r_mem[w_pc_inc1[AW-1:0]];
                            w_state_nxt   = S_STEP_HI;
                            w_ss_wait_nxt = w_ss_arm;
                        end
                    end else if (w_step_cnt_inc == STEP_LIMIT) begin
                        w_state_nxt = S_HALT;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = S_STEP_HI;
                        w_ss_wait_nxt = w_ss_arm;
                    end
                end
            end

            S_HALT: begin
                if (!bus.RUN) begin
                    w_state_nxt  = S_IDLE;
                    w_halted_nxt = 1'b0;
                    w_fault_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK50M) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_pc       <= '0;
            r_prog_len <= '0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
            r_imm      <= 1'b0;
            r_step_cnt <= '0;
            r_phase    <= '0;
            r_ss_wait  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word     <= w_word_nxt;
            r_pc       <= w_pc_nxt;
            r_prog_len <= w_prog_len_nxt;
            r_halted   <= w_halted_nxt;
            r_fault    <= w_fault_nxt;
            r_imm      <= w_imm_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_ss_wait  <= w_ss_wait_nxt;
        end
    end

    // Program memory keeps its contents across reset.
    always_ff @(posedge CLK50M) begin
        if (w_mem_we) begin
            r_mem[r_prog_len[AW-1:0]] <= bus.WR_DATA;
        end
    end

    assign bus.WORD      = r_word;
    assign bus.STEP      = (r_state == S_STEP_HI) && !r_ss_wait;
    assign bus.PC        = r_pc;
    assign bus.PROG_LEN  = r_prog_len;
    assign bus.BUSY      = (r_state == S_LOAD) || (r_state == S_STEP_HI) || (r_state == S_STEP_LO);
    assign bus.HALTED    = r_halted;
    assign bus.FAULT     = r_fault;
    assign bus.DBG_STATE = r_state;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: load, plain run, immediates, watchdog, abort, reset.
module tb_program_sequencer;
    localparam int DEPTH       = 16;
    localparam int HALF_PERIOD = 4;
    localparam int MAX_STEPS   = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_HALT = 3'd4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [9:0] prog_buf [32];

    program_sequencer_if #(.DEPTH(DEPTH)) bus ();

    program_sequencer #(
        .DEPTH(DEPTH),
        .HALF_PERIOD(HALF_PERIOD),
        .MAX_STEPS(MAX_STEPS)
    ) dut (
        .CLK50M(clk),
        .RST(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_prog(input int n);
        bus.LOAD_EN = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            bus.WR_STB  = 1'b1;
            bus.WR_DATA = prog_buf[i];
            tick();
        end
        bus.WR_STB  = 1'b0;
        bus.LOAD_EN = 1'b0;
        tick();
    endtask

    // Waits for STEP high, measures the high phase, presents DONE/EXT across the
    // low phase and returns just after the end-of-step decision edge.
    task automatic run_step(input logic done, input logic ext, input logic drop_run,
                            output logic [9:0] word, output int hi, output logic stable);
        int guard;
        guard = 0;
        while (bus.STEP !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        word   = bus.WORD;
        stable = 1'b1;
        hi     = 0;
        if (drop_run) bus.RUN = 1'b0;
        while (bus.STEP === 1'b1 && hi < 40) begin
            if (bus.WORD !== word) stable = 1'b0;
            hi++;
            tick();
        end
        bus.DONE = done;
        bus.EXT  = ext;
        repeat (HALF_PERIOD) tick();
        bus.DONE = 1'b0;
        bus.EXT  = 1'b0;
    endtask

    task automatic end_run();
        bus.RUN = 1'b0;
        tick();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.WORD !== 10'h000) begin n_fail++; $display("FAIL reset_word got=%h exp=000", bus.WORD); end
        n_tests++; if (bus.STEP !== 1'b0) begin n_fail++; $display("FAIL reset_step got=%b exp=0", bus.STEP); end
        n_tests++; if (bus.PC !== 4'd0) begin n_fail++; $display("FAIL reset_pc got=%0d exp=0", bus.PC); end
        n_tests++; if (bus.PROG_LEN !== 5'd0) begin n_fail++; $display("FAIL reset_len got=%0d exp=0", bus.PROG_LEN); end
        n_tests++; if ({bus.BUSY, bus.HALTED, bus.FAULT} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {bus.BUSY, bus.HALTED, bus.FAULT}); end
        n_tests++; if (bus.DBG_STATE !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", bus.DBG_STATE, ST_IDLE); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        logic [9:0] w;
        int hi;
        logic st;
        logic [9:0] exp3 [3];
        exp3[0] = 10'h101; exp3[1] = 10'h202; exp3[2] = 10'h303;
        for (int i = 0; i < 3; i++) prog_buf[i] = exp3[i];
        bus.LOAD_EN = 1'b1;
        tick();
        n_tests++; if (bus.DBG_STATE !== ST_LOAD || bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL load_enter state=%0d busy=%b exp=%0d/1", bus.DBG_STATE, bus.BUSY, ST_LOAD); end
        bus.LOAD_EN = 1'b0;
        tick();
        load_prog(3);
        n_tests++; if (bus.PROG_LEN !== 5'd3) begin n_fail++; $display("FAIL load_len got=%0d exp=3", bus.PROG_LEN); end
        bus.RUN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_step(1'b1, 1'b0, 1'b0, w, hi, st);
            n_tests++; if (w !== exp3[k]) begin n_fail++; $display("FAIL load_mem%0d got=%h exp=%h", k, w, exp3[k]); end
        end
        n_tests++; if (bus.HALTED !== 1'b1 || bus.PC !== 4'd3) begin n_fail++; $display("FAIL load_halt halted=%b pc=%0d exp=1/3", bus.HALTED, bus.PC); end
        end_run();
        n_tests++; if (bus.HALTED !== 1'b0 || bus.DBG_STATE !== ST_IDLE) begin n_fail++; $display("FAIL load_clear halted=%b state=%0d exp=0/0", bus.HALTED, bus.DBG_STATE); end

        for (int i = 0; i <= DEPTH; i++) prog_buf[i] = 10'(10'h010 + i);
        load_prog(DEPTH + 1);
        n_tests++; if (bus.PROG_LEN !== 5'd16) begin n_fail++; $display("FAIL load_full_len got=%0d exp=16", bus.PROG_LEN); end
        bus.RUN = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            run_step(1'b1, 1'b0, 1'b0, w, hi, st);
            n_tests++; if (w !== 10'(10'h010 + k)) begin n_fail++; $display("FAIL load_full_mem%0d got=%h exp=%h", k, w, 10'(10'h010 + k)); end
        end
        n_tests++; if (bus.HALTED !== 1'b1 || bus.FAULT !== 1'b0) begin n_fail++; $display("FAIL load_full_halt halted=%b fault=%b exp=1/0", bus.HALTED, bus.FAULT); end
        end_run();
    endtask

    task automatic test_run_plain();
        logic [9:0] w;
        int hi;
        logic st;
        logic [9:0] exp_w;
        prog_buf[0] = 10'h041; prog_buf[1] = 10'h082;
        load_prog(2);
        bus.RUN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_w = (k < 3) ? 10'h041 : 10'h082;
            run_step((k == 2 || k == 5), 1'b0, 1'b0, w, hi, st);
            n_tests++; if (w !== exp_w || st !== 1'b1) begin n_fail++; $display("FAIL plain_word%0d got=%h stable=%b exp=%h/1", k, w, st, exp_w); end
            n_tests++; if (hi != HALF_PERIOD) begin n_fail++; $display("FAIL plain_high%0d got=%0d exp=%0d", k, hi, HALF_PERIOD); end
            if (k == 2) begin
                n_tests++; if (bus.PC !== 4'd1) begin n_fail++; $display("FAIL plain_pc1 got=%0d exp=1", bus.PC); end
            end
        end
        n_tests++; if (bus.HALTED !== 1'b1 || bus.PC !== 4'd2 || bus.STEP !== 1'b0 || bus.BUSY !== 1'b0) begin
            n_fail++; $display("FAIL plain_halt halted=%b pc=%0d step=%b busy=%b exp=1/2/0/0", bus.HALTED, bus.PC, bus.STEP, bus.BUSY);
        end
        end_run();
    endtask

    task automatic test_immediate();
        logic [9:0] w;
        int hi;
        logic st;
        prog_buf[0] = 10'h200; prog_buf[1] = 10'h155; prog_buf[2] = 10'h041;
        load_prog(3);
        bus.RUN = 1'b1;
        run_step(1'b0, 1'b1, 1'b0, w, hi, st);
        n_tests++; if (w !== 10'h200) begin n_fail++; $display("FAIL imm_step1 got=%h exp=200", w); end
        n_tests++; if (bus.WORD !== 10'h155 || bus.PC !== 4'd0) begin n_fail++; $display("FAIL imm_fetch word=%h pc=%0d exp=155/0", bus.WORD, bus.PC); end
        run_step(1'b1, 1'b0, 1'b0, w, hi, st);
        n_tests++; if (w !== 10'h155 || hi != HALF_PERIOD) begin n_fail++; $display("FAIL imm_step2 got=%h hi=%0d exp=155/%0d", w, hi, HALF_PERIOD); end
        n_tests++; if (bus.PC !== 4'd2 || bus.WORD !== 10'h041) begin n_fail++; $display("FAIL imm_skip pc=%0d word=%h exp=2/041", bus.PC, bus.WORD); end
        run_step(1'b1, 1'b0, 1'b0, w, hi, st);
        n_tests++; if (bus.HALTED !== 1'b1 || bus.PC !== 4'd3) begin n_fail++; $display("FAIL imm_halt halted=%b pc=%0d exp=1/3", bus.HALTED, bus.PC); end
        end_run();
    endtask

    task automatic test_imm_past_end();
        logic [9:0] w;
        int hi;
        logic st;
        prog_buf[0] = 10'h200;
        load_prog(1);
        bus.RUN = 1'b1;
        run_step(1'b0, 1'b1, 1'b0, w, hi, st);
        n_tests++; if (bus.FAULT !== 1'b1 || bus.HALTED !== 1'b0 || bus.STEP !== 1'b0) begin
            n_fail++; $display("FAIL imm_end fault=%b halted=%b step=%b exp=1/0/0", bus.FAULT, bus.HALTED, bus.STEP);
        end
        n_tests++; if (bus.DBG_STATE !== ST_HALT) begin n_fail++; $display("FAIL imm_end_state got=%0d exp=%0d", bus.DBG_STATE, ST_HALT); end
        end_run();
        n_tests++; if (bus.FAULT !== 1'b0) begin n_fail++; $display("FAIL imm_end_clear got=%b exp=0", bus.FAULT); end
    endtask

    task automatic test_watchdog();
        logic [9:0] w;
        int hi;
        logic st;
        prog_buf[0] = 10'h041; prog_buf[1] = 10'h082;
        load_prog(2);
        bus.RUN = 1'b1;
        for (int k = 0; k < MAX_STEPS; k++) begin
            run_step(1'b0, 1'b0, 1'b0, w, hi, st);
            n_tests++; if (w !== 10'h041 || hi != HALF_PERIOD) begin n_fail++; $display("FAIL wdog_step%0d word=%h hi=%0d exp=041/%0d", k, w, hi, HALF_PERIOD); end
            if (k == MAX_STEPS - 2) begin
                n_tests++; if (bus.FAULT !== 1'b0 || bus.STEP !== 1'b1) begin n_fail++; $display("FAIL wdog_early fault=%b step=%b exp=0/1", bus.FAULT, bus.STEP); end
            end
        end
        n_tests++; if (bus.FAULT !== 1'b1 || bus.DBG_STATE !== ST_HALT || bus.WORD !== 10'h041) begin
            n_fail++; $display("FAIL wdog_fault fault=%b state=%0d word=%h exp=1/%0d/041", bus.FAULT, bus.DBG_STATE, bus.WORD, ST_HALT);
        end
        end_run();
        n_tests++; if (bus.FAULT !== 1'b0 || bus.DBG_STATE !== ST_IDLE) begin n_fail++; $display("FAIL wdog_clear fault=%b state=%0d exp=0/0", bus.FAULT, bus.DBG_STATE); end
    endtask

    task automatic test_abort();
        logic [9:0] w;
        int hi;
        logic st;
        prog_buf[0] = 10'h041; prog_buf[1] = 10'h082;
        load_prog(2);
        bus.RUN = 1'b1;
        run_step(1'b1, 1'b0, 1'b0, w, hi, st);
        run_step(1'b0, 1'b0, 1'b1, w, hi, st);
        n_tests++; if (w !== 10'h082 || hi != HALF_PERIOD) begin n_fail++; $display("FAIL abort_step word=%h hi=%0d exp=082/%0d", w, hi, HALF_PERIOD); end
        n_tests++; if (bus.DBG_STATE !== ST_IDLE || bus.PC !== 4'd0 || bus.WORD !== 10'h000 || bus.STEP !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle state=%0d pc=%0d word=%h step=%b exp=0/0/000/0", bus.DBG_STATE, bus.PC, bus.WORD, bus.STEP);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        prog_buf[0] = 10'h041;
        load_prog(1);
        bus.RUN = 1'b1;
        guard = 0;
        while (bus.STEP !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        tick();
        n_tests++; if (bus.STEP !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre step=%b exp=1", bus.STEP); end
        rst = 1'b1;
        tick();
        n_tests++; if (bus.STEP !== 1'b0 || bus.WORD !== 10'h000 || bus.PROG_LEN !== 5'd0 || bus.BUSY !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_out step=%b word=%h len=%0d busy=%b exp=0/000/0/0", bus.STEP, bus.WORD, bus.PROG_LEN, bus.BUSY);
        end
        n_tests++; if (bus.DBG_STATE !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state got=%0d exp=0", bus.DBG_STATE); end
        bus.RUN = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_empty_run();
        bus.RUN = 1'b1;
        tick();
        n_tests++; if (bus.FAULT !== 1'b1 || bus.DBG_STATE !== ST_HALT || bus.STEP !== 1'b0) begin
            n_fail++; $display("FAIL empty_run fault=%b state=%0d step=%b exp=1/%0d/0", bus.FAULT, bus.DBG_STATE, bus.STEP, ST_HALT);
        end
        end_run();
        n_tests++; if (bus.FAULT !== 1'b0) begin n_fail++; $display("FAIL empty_clear got=%b exp=0", bus.FAULT); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.LOAD_EN = 1'b0;
        bus.WR_STB  = 1'b0;
        bus.WR_DATA = '0;
        bus.RUN     = 1'b0;
        bus.DONE    = 1'b0;
        bus.EXT     = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        bus.STEP_REQ = 1'b0;
        bus.SS_MODE  = 1'b0;
`endif
        test_reset();
        test_load();
        test_run_plain();
        test_immediate();
        test_imm_past_end();
        test_watchdog();
        test_abort();
        test_reset_mid();
        test_empty_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Drives the processor top from the other end of its front-panel interface.
- Replaces the human at the switches and the clock button. It stores a program of 10-bit words (instructions plus inline immediates), presents each word on the processor's switch input, and generates a debounce-free step clock.
- Advances through the program using the processor's done and external-data-request signals.

Parameters:
- DEPTH, 16, number of 10-bit program words (power of two, ≥2).
- HALF_PERIOD, 4, CLK50M cycles STEP stays high, and again low, per step (≥2).
- MAX_STEPS, 8, steps allowed per instruction without DONE before fault.

Ports:
- CLK50M  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- LOAD_EN  input  1  level; program-load mode.
- WR_STB  input  1  one-cycle strobe; append WR_DATA to program.
- WR_DATA  input  10  program word to append.
- RUN  input  1  level; execute the stored program.
- DONE  input  1  processor instruction-complete (controller Clr / done LED).
- EXT  input  1  processor requests external data for the next step.
- WORD  output  10  word driven onto the processor switch input.
- STEP  output  1  step clock to the processor (replaces clkButton).
- PC  output  $clog2(DEPTH)  address of the current instruction word.
- PROG_LEN  output  $clog2(DEPTH)+1  words loaded.
- BUSY  output  1  high in LOAD, STEP_HI, STEP_LO.
- HALTED  output  1  program finished normally.
- FAULT  output  1  abnormal stop.

Behaviour:
- Reset: WORD=0, STEP=0, PC=0, PROG_LEN=0, BUSY=0, HALTED=0, FAULT=0, imm flag=0, step counter=0, state IDLE. Memory contents are not reset.
- States: IDLE, LOAD, STEP_HI, STEP_LO, HALT.
- IDLE, LOAD_EN=1:
  - → LOAD; PROG_LEN cleared to 0 on entry.
  - LOAD_EN has priority over RUN.
- IDLE, RUN=1, LOAD_EN=0:
  - PROG_LEN=0 → HALT with FAULT=1.
  - Otherwise PC=0, WORD=mem[0], → STEP_HI.
- LOAD:
  - Each WR_STB writes mem[PROG_LEN]=WR_DATA and increments PROG_LEN.
  - WR_STB when PROG_LEN==DEPTH is ignored (no wrap).
  - LOAD_EN low → IDLE.
- STEP_HI:
  - STEP=1 for exactly HALF_PERIOD cycles, then → STEP_LO.
  - WORD is stable for the whole step.
- STEP_LO:
  - STEP=0 for HALF_PERIOD cycles.
  - DONE and EXT are sampled on the last cycle, and the step counter increments.
- End-of-step decision, in priority order:
  - RUN=0 → IDLE, PC=0, imm=0, WORD=0.
  - DONE=1 → PC ← PC+1+imm, imm=0, counter=0. If the new PC ≥ PROG_LEN → HALT with HALTED=1. Otherwise WORD=mem[new PC], → STEP_HI.
  - EXT=1 → imm=1. If PC+1 ≥ PROG_LEN → HALT with FAULT=1. Otherwise WORD=mem[PC+1], → STEP_HI.
  - Counter == MAX_STEPS → HALT with FAULT=1.
  - Otherwise WORD unchanged, → STEP_HI.
- Immediate words: PC always points at the instruction word. An immediate occupies PC+1 and is skipped once DONE is seen.
- HALT: STEP=0, WORD held, BUSY=0. Stays until RUN=0 → IDLE, which clears HALTED and FAULT.
- STEP is a 2×HALF_PERIOD-cycle square pulse per step. It is never high across a state abort; RUN is checked only at step end.
- RST mid-step: STEP drops on the next edge, everything returns to reset values.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined: adds input STEP_REQ (1 bit) and input SS_MODE (1 bit). When SS_MODE=1, each entry to STEP_HI waits in STEP_HI with STEP=0 until a STEP_REQ cycle, then runs the normal HALF_PERIOD high phase.
- Not defined: no extra ports; steps run back-to-back.

Test Plan:
- Load: LOAD_EN=1, write 0x101, 0x202, 0x303 → PROG_LEN=3, mem[0..2] match. Then write DEPTH+1 words → PROG_LEN=16, extra ignored.
- Run with no immediates: program {0x041, 0x082}, DONE pulsed at step 3 of each instruction → WORD 0x041 for 3 steps, then 0x082, then HALTED=1, PC=2. Each STEP high exactly 4 cycles.
- Immediate fetch: program {0x200, 0x155, 0x041}, EXT=1 at end of step 1, DONE at end of step 2 → step 2 shows WORD=0x155. Next instruction PC=2, WORD=0x041.
- Immediate past end: program {0x200}, EXT=1 at end of step 1 → FAULT=1, STEP=0.
- Watchdog: DONE never asserted → FAULT after exactly 8 steps. RUN=0 then clears FAULT, state IDLE.
- Abort/reset: RUN dropped mid-STEP_HI → step completes, then IDLE with PC=0. RST asserted mid-step → STEP=0 next cycle, all outputs at reset values.
